// File: rtl/turbo_pingpong_interleaver.sv
// Turbo-encoder input stage with two ping-pong symbol banks.
// One bank fills from the input stream while the other streams natural-order
// and QPP-interleaved symbol pairs. Interleaver addresses are generated
// incrementally with mod-K adders, so no multiplier or ROM is needed. A fixed
// termination gap (term=1) follows every block.
module turbo_pingpong_interleaver #(
  parameter int DATA_W      = 1,
  parameter int ADDR_W      = 12,
  parameter int TERM_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] blk_len,
  input  logic [ADDR_W-1:0] qpp_f1,
  input  logic [ADDR_W-1:0] qpp_f2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sys,
  output logic [DATA_W-1:0] out_int,
  output logic              out_first,
  output logic              out_last,
  output logic              term
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TC_W  = $clog2(TERM_CYCLES + 1);

  typedef enum logic {W_FILL = 1'b0, W_FULL = 1'b1} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_STREAM = 2'd1, R_TERM = 2'd2} r_state_t;

  // (a + b) mod k for a, b < k
  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b,
                                                input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, k}) sum = sum - {1'b0, k};
    return sum[ADDR_W-1:0];
  endfunction

  // (2 * a) mod k, reduced by up to two subtractions
  function automatic logic [ADDR_W-1:0] mod_dbl(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] dbl;
    dbl = {a, 1'b0};
    if (dbl >= {1'b0, k}) dbl = dbl - {1'b0, k};
    if (dbl >= {1'b0, k}) dbl = dbl - {1'b0, k};
    return dbl[ADDR_W-1:0];
  endfunction

  // Both banks in one array; the bank bit is the address MSB.
  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  // Write side
  logic              w_bank_reg;
  logic [ADDR_W-1:0] w_cnt_reg;
  logic [ADDR_W-1:0] bank_k_reg  [2];
  logic [ADDR_W-1:0] bank_f1_reg [2];
  logic [ADDR_W-1:0] bank_f2_reg [2];

  // Read side
  logic              r_bank_reg;
  logic [ADDR_W-1:0] rk_reg, idx_reg, pi_reg, g_reg, step_reg;
  logic [TC_W-1:0]   term_cnt_reg;

  logic in_ready_reg, out_valid_reg, term_reg, out_first_reg, out_last_reg;
  logic in_ready_next, out_valid_next, term_next;
  logic [DATA_W-1:0] out_sys_reg, out_int_reg;

  logic              accept, xfer, swap, w_fill_done, at_last, load;
  logic [ADDR_W-1:0] blk_k, cur_k, swap_k, swap_f1, swap_f2;
  logic [ADDR_W-1:0] idx_next, pi_next, g_next, k_next;
  logic              rd_bank;

  assign accept      = in_valid && in_ready_reg;
  assign xfer        = out_valid_reg && out_ready;
  assign swap        = (w_state_reg == W_FULL) && (r_state_reg == R_IDLE);
  assign blk_k       = (blk_len == '0) ? ADDR_W'(1) : blk_len;
  // K is taken live on the first symbol because a K=1 block completes on it.
  assign cur_k       = (w_cnt_reg == '0) ? blk_k : bank_k_reg[w_bank_reg];
  assign w_fill_done = (w_cnt_reg == cur_k - ADDR_W'(1));
  assign swap_k      = bank_k_reg[w_bank_reg];
  assign swap_f1     = bank_f1_reg[w_bank_reg];
  assign swap_f2     = bank_f2_reg[w_bank_reg];
  assign at_last     = (idx_reg == rk_reg - ADDR_W'(1));
  assign load        = swap || ((r_state_reg == R_STREAM) && xfer && !at_last);
  assign rd_bank     = swap ? w_bank_reg : r_bank_reg;

  // Next read index and interleaver state: restart on swap, else step once.
  always_comb begin
    idx_next = idx_reg + ADDR_W'(1);
    pi_next  = mod_add(pi_reg, g_reg, rk_reg);
    g_next   = mod_add(g_reg, step_reg, rk_reg);
    k_next   = rk_reg;
    if (swap) begin
      idx_next = '0;
      pi_next  = '0;
      g_next   = mod_add(swap_f1, swap_f2, swap_k);
      k_next   = swap_k;
    end
  end

  // State and control-output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_reg   <= W_FILL;
      r_state_reg   <= R_IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      term_reg      <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      w_state_reg   <= w_state_next;
      r_state_reg   <= r_state_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      term_reg      <= term_next;
      if (load) begin
        out_first_reg <= (idx_next == '0);
        out_last_reg  <= (idx_next == k_next - ADDR_W'(1));
      end
    end
  end

  // Next-state logic for the write and read FSMs
  always_comb begin
    w_state_next = w_state_reg;
    r_state_next = r_state_reg;
    case (w_state_reg)
      W_FILL:  if (accept && w_fill_done) w_state_next = W_FULL;
      W_FULL:  if (swap) w_state_next = W_FILL;
      default: w_state_next = W_FILL;
    endcase
    case (r_state_reg)
      R_IDLE:   if (swap) r_state_next = R_STREAM;
      R_STREAM: if (xfer && at_last) r_state_next = R_TERM;
      R_TERM:   if (term_cnt_reg == TC_W'(TERM_CYCLES - 1)) r_state_next = R_IDLE;
      default:  r_state_next = R_IDLE;
    endcase
  end

  // Control outputs follow the upcoming state so they can be registered
  always_comb begin
    in_ready_next  = (w_state_next == W_FILL);
    out_valid_next = (r_state_next == R_STREAM);
    term_next      = (r_state_next == R_TERM);
  end

  // Write pointer, bank toggle and per-bank block parameters
  always_ff @(posedge clk) begin
    if (reset) begin
      w_bank_reg <= 1'b0;
      w_cnt_reg  <= '0;
    end else begin
      if (accept) begin
        if (w_cnt_reg == '0) begin
          bank_k_reg[w_bank_reg]  <= blk_k;
          bank_f1_reg[w_bank_reg] <= qpp_f1;
          bank_f2_reg[w_bank_reg] <= qpp_f2;
        end
        w_cnt_reg <= w_fill_done ? '0 : w_cnt_reg + ADDR_W'(1);
      end
      if (swap) w_bank_reg <= ~w_bank_reg;
    end
  end

  // Symbol store
  always_ff @(posedge clk) begin
    if (accept) mem[{w_bank_reg, w_cnt_reg}] <= in_data;
  end

  // Read-side block state, interleaver recursion and termination counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_reg   <= 1'b0;
      rk_reg       <= ADDR_W'(1);
      idx_reg      <= '0;
      pi_reg       <= '0;
      g_reg        <= '0;
      step_reg     <= '0;
      term_cnt_reg <= '0;
    end else begin
      if (swap) begin
        r_bank_reg <= w_bank_reg;
        rk_reg     <= swap_k;
        step_reg   <= mod_dbl(swap_f2, swap_k);
      end
      if (load) begin
        idx_reg <= idx_next;
        pi_reg  <= pi_next;
        g_reg   <= g_next;
      end
      term_cnt_reg <= (r_state_reg == R_TERM) ? term_cnt_reg + TC_W'(1) : '0;
    end
  end

  // Registered dual read of the streaming bank; held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sys_reg <= '0;
      out_int_reg <= '0;
    end else if (load) begin
      out_sys_reg <= mem[{rd_bank, idx_next}];
      out_int_reg <= mem[{rd_bank, pi_next}];
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign term      = term_reg;
  assign out_first = out_first_reg;
  assign out_last  = out_last_reg;
  assign out_sys   = out_sys_reg;
  assign out_int   = out_int_reg;

endmodule

// File: tb/tb_turbo_pingpong_interleaver.sv
// Bench for turbo_pingpong_interleaver: directed block sequences with a
// scoreboard of expected (sys, int, first, last) pairs computed from the
// closed-form QPP formula.
module tb_turbo_pingpong_interleaver;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int TC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] blk_len, qpp_f1, qpp_f2;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_sys, out_int;
  logic          out_first, out_last, term;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb[$];
  logic rnd_mode = 1'b0;
  int first_wait, other_wait;

  turbo_pingpong_interleaver #(.DATA_W(DW), .ADDR_W(AW), .TERM_CYCLES(TC)) dut (
    .clk(clk), .reset(reset),
    .blk_len(blk_len), .qpp_f1(qpp_f1), .qpp_f2(qpp_f2),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sys(out_sys), .out_int(out_int),
    .out_first(out_first), .out_last(out_last), .term(term)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Queue expected pairs for one block, then feed its symbols.
  task automatic send_block(input int len_in, input int f1, input int f2, input int seed);
    int k;
    int waits;
    logic ok;
    longint pi;
    k = (len_in == 0) ? 1 : len_in;
    blk_len = AW'(len_in);
    qpp_f1  = AW'(f1);
    qpp_f2  = AW'(f2);
    for (int i = 0; i < k; i++) begin
      pi = (longint'(f1) * i + longint'(f2) * i * i) % k;
      sb.push_back({8'((i + seed) % 256), 8'((pi + seed) % 256), (i == 0), (i == k - 1)});
    end
    other_wait = 0;
    first_wait = 0;
    for (int i = 0; i < k; i++) begin
      in_valid = 1'b1;
      in_data  = 8'((i + seed) % 256);
      waits = 0;
      ok = 1'b0;
      while (!ok && waits < 2000) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        if (!ok) waits++;
      end
      if (!ok) chk("in_timeout", 32'(ok), 32'd1);
      if (i == 0) first_wait = waits;
      else other_wait += waits;
    end
    $display("block K=%0d f1=%0d f2=%0d seed=%0d accepted first_wait=%0d", k, f1, f2, seed, first_wait);
  endtask

  // Wait for every queued pair to come out, then let the term gap finish.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: always 1, or a coin flip each cycle
  initial begin : ready_drv
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare, stall stability, term-gap length
  initial begin : monitor
    logic [17:0] obs, exp, held;
    logic hold_pending, expect_term;
    int term_run;
    hold_pending = 1'b0;
    expect_term = 1'b0;
    term_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_pending = 1'b0;
        expect_term = 1'b0;
        term_run = 0;
      end else begin
        obs = {out_sys, out_int, out_first, out_last};
        if (hold_pending) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_hold", 32'(obs), 32'(held));
          hold_pending = 1'b0;
        end
        if (expect_term) begin
          chk("term_start", 32'(term), 32'd1);
          expect_term = 1'b0;
        end
        if (term) begin
          term_run++;
          chk("term_no_valid", 32'(out_valid), 32'd0);
        end else if (term_run != 0) begin
          chk("term_len", 32'(term_run), 32'(TC));
          term_run = 0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("stale_pair", 32'(out_valid), 32'd0);
          end else begin
            exp = sb.pop_front();
            $display("pair sys=%0d int=%0d first=%0d last=%0d", out_sys, out_int, out_first, out_last);
            chk("pair", 32'(obs), 32'(exp));
            if (exp[0]) expect_term = 1'b1;
          end
        end else if (out_valid) begin
          held = obs;
          hold_pending = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    in_valid = 1'b0;
    in_data  = '0;
    blk_len  = '0;
    qpp_f1   = '0;
    qpp_f2   = '0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_term", 32'(term), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Single K=40 block, full-rate downstream
    send_block(40, 3, 10, 0);
    chk("t2_first_wait", 32'(first_wait), 32'd0);
    chk("t2_other_wait", 32'(other_wait), 32'd0);
    in_valid = 1'b0;
    drain();

    // Same block with random backpressure
    rnd_mode = 1'b1;
    send_block(40, 3, 10, 0);
    in_valid = 1'b0;
    drain();
    rnd_mode = 1'b0;

    // Three back-to-back blocks: fill overlaps streaming
    send_block(40, 3, 10, 0);
    send_block(40, 3, 10, 64);
    chk("t4_swap_bubble", 32'(first_wait), 32'd1);
    chk("t4_b2_other_wait", 32'(other_wait), 32'd0);
    send_block(40, 3, 10, 128);
    chk("t4_b3_other_wait", 32'(other_wait), 32'd0);
    in_valid = 1'b0;
    drain();

    // Per-bank parameters: K=40 followed by K=48 with different QPP
    send_block(40, 3, 10, 16);
    send_block(48, 7, 12, 32);
    in_valid = 1'b0;
    drain();

    // K=1 and blk_len=0 blocks
    send_block(1, 0, 0, 5);
    in_valid = 1'b0;
    drain();
    send_block(0, 0, 0, 9);
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a stream
    send_block(40, 3, 10, 0);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_term", 32'(term), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_post_in_ready", 32'(in_ready), 32'd1);
    chk("mid_post_out_valid", 32'(out_valid), 32'd0);
    chk("mid_post_term", 32'(term), 32'd0);
    repeat (20) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send_block(40, 3, 10, 200);
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
